// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan controller:
//   - scan_state_t  : scan FSM state encoding (blank slot / show slot)
//   - SEG_OFF       : active-high "all segments off" pattern
//   - HEX_SEG_TABLE : 0-F glyphs, active-high, bit6=g .. bit0=a
// ---------------------------------------------------------------------------
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// ---------------------------------------------------------------------------
// seg_hex_decoder
// Combinational hex nibble to seven-segment glyph lookup (active-high).
// Ports:
//   nibble : 4-bit hex value
//   seg    : segments, bit6=g .. bit0=a, 1 = lit
// ---------------------------------------------------------------------------
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed seven-segment scan scheduler. Each digit gets a blank
// slot (BLANK_TICKS) followed by a show slot (SHOW_TICKS), advanced by the
// Tick_In strobe. Display data is double-buffered: Load writes the shadow,
// and the shadow is committed to the active copy at the next frame boundary
// (entry to digit 0), acknowledged by Load_Ack.
// Ports:
//   Clk_In      : system clock
//   RST         : asynchronous active-high reset
//   Tick_In     : 1-cycle scan strobe
//   Data_In     : hex nibbles, digit i = Data_In[4i+3:4i]
//   Dp_In       : decimal-point bits per digit
//   Digit_En    : live per-digit anode enable
//   Lz_Suppress : live leading-zero blanking enable
//   Load        : 1-cycle pulse, capture Data_In/Dp_In into the shadow
//   Load_Ack    : 1-cycle pulse when the shadow is committed
//   An_Out      : digit anodes      (board polarity)
//   Seg_Out     : segments g..a     (board polarity)
//   Dp_Out      : decimal point     (board polarity)
//   Frame_Start : 1-cycle pulse on entry to digit 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_TICKS  = 3,
  parameter int BLANK_TICKS = 1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    Clk_In,
  input  logic                    RST,
  input  logic                    Tick_In,
  input  logic [4*NUM_DIGITS-1:0] Data_In,
  input  logic [NUM_DIGITS-1:0]   Dp_In,
  input  logic [NUM_DIGITS-1:0]   Digit_En,
  input  logic                    Lz_Suppress,
  input  logic                    Load,
  output logic                    Load_Ack,
  output logic [NUM_DIGITS-1:0]   An_Out,
  output logic [6:0]              Seg_Out,
  output logic                    Dp_Out,
  output logic                    Frame_Start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_TICKS - 1);
  // With no blank phase the reset-time blank slot still lasts one tick.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam bit               HAS_BLANK  = (BLANK_TICKS > 0);

  // XOR masks that turn active-high drive into board polarity.
  localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};

  scan_state_t             state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    boundary_s;
  logic                    commit_s;

  logic [4*NUM_DIGITS-1:0] shadow_data_r, active_data_r, active_data_n_s;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, active_dp_r, active_dp_n_s;
  logic                    pending_r;

  logic [NUM_DIGITS-1:0]   zero_above_s;
  logic [3:0]              dec_nib_s;
  logic [6:0]              dec_seg_s;
  logic [NUM_DIGITS-1:0]   an_hi_s;
  logic [6:0]              seg_hi_s;
  logic                    dp_hi_s;

  logic                    load_ack_r, frame_start_r, dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;

  // Scan FSM next state: advances only on Tick_In
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    boundary_s = 1'b0;
    if (Tick_In) begin
      case (state_r)
        S_BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = S_SHOW;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            cnt_s   = '0;
            state_s = HAS_BLANK ? S_BLANK : S_SHOW;
            if (idx_r == IDX_LAST) begin
              idx_s      = '0;
              boundary_s = 1'b1;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = S_BLANK;
          idx_s   = '0;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign commit_s = boundary_s & pending_r;

  // Active copy as it will be after this edge, so digit 0 of a new frame
  // already shows freshly committed data
  always_comb begin
    if (commit_s) begin
      active_data_n_s = shadow_data_r;
      active_dp_n_s   = shadow_dp_r;
    end else begin
      active_data_n_s = active_data_r;
      active_dp_n_s   = active_dp_r;
    end
  end

  // zero_above_s[i] = digit i and all higher digits are zero
  always_comb begin
    logic run;
    run          = 1'b1;
    zero_above_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run             = run & (active_data_n_s[4*i +: 4] == 4'h0);
      zero_above_s[i] = run;
    end
  end

  assign dec_nib_s = active_data_n_s[{idx_s, 2'b00} +: 4];

  seg_hex_decoder u_hex_decoder (
    .nibble (dec_nib_s),
    .seg    (dec_seg_s)
  );

  // Active-high drive for the slot being entered
  always_comb begin
    an_hi_s  = '0;
    seg_hi_s = SEG_OFF;
    dp_hi_s  = 1'b0;
    if (state_s == S_SHOW) begin
      if (Digit_En[idx_s]) begin
        an_hi_s[idx_s] = 1'b1;
      end else begin
        an_hi_s = '0;
      end
      if (Lz_Suppress && (idx_s != '0) && zero_above_s[idx_s]) begin
        seg_hi_s = SEG_OFF;
      end else begin
        seg_hi_s = dec_seg_s;
      end
      dp_hi_s = active_dp_n_s[idx_s];
    end else begin
      an_hi_s = '0;
    end
  end

  // State, buffers, handshake pulses and polarity-adjusted output registers
  always_ff @(posedge Clk_In or posedge RST) begin
    if (RST) begin
      state_r       <= S_BLANK;
      idx_r         <= '0;
      cnt_r         <= '0;
      shadow_data_r <= '0;
      shadow_dp_r   <= '0;
      active_data_r <= '0;
      active_dp_r   <= '0;
      pending_r     <= 1'b0;
      load_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
      an_r          <= AN_POL;
      seg_r         <= SEG_POL;
      dp_r          <= ACTIVE_LOW;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      active_data_r <= active_data_n_s;
      active_dp_r   <= active_dp_n_s;
      // A Load on the boundary edge refills the shadow after the old
      // contents were committed, so it stays pending for the next frame.
      if (Load) begin
        shadow_data_r <= Data_In;
        shadow_dp_r   <= Dp_In;
        pending_r     <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      load_ack_r    <= commit_s;
      frame_start_r <= boundary_s;
      an_r          <= an_hi_s ^ AN_POL;
      seg_r         <= seg_hi_s ^ SEG_POL;
      dp_r          <= dp_hi_s ^ ACTIVE_LOW;
    end
  end

  assign Load_Ack    = load_ack_r;
  assign Frame_Start = frame_start_r;
  assign An_Out      = an_r;
  assign Seg_Out     = seg_r;
  assign Dp_Out      = dp_r;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed seven-segment scan scheduler. It consumes the 1-cycle tick strobe produced by the system clock divider (nominally 4000 Hz from 100 MHz) and shares the common segment bus between NUM_DIGITS digits. Each digit gets a blank slot followed by a show slot. Display data is double-buffered and committed only at frame boundaries through a Load/Load_Ack handshake. The block sits between the register/CPU side and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SHOW_TICKS, 3, ticks each digit is driven (>=1)
BLANK_TICKS, 1, ticks all anodes are off before each digit, for ghosting guard (0 = no blank phase)
ACTIVE_LOW, 1, 1 = An_Out/Seg_Out/Dp_Out active-low board pins; 0 = active-high

Ports:
Clk_In  input  1  system clock, 100 MHz
RST  input  1  asynchronous, active-high reset
Tick_In  input  1  single-cycle scan strobe from the clock divider
Data_In  input  4*NUM_DIGITS  hex nibbles; digit i = Data_In[4i+3:4i]; digit 0 is least significant
Dp_In  input  NUM_DIGITS  decimal-point bits per digit
Digit_En  input  NUM_DIGITS  per-digit enable, applied live (not buffered)
Lz_Suppress  input  1  leading-zero blanking enable, applied live
Load  input  1  1-cycle pulse; captures Data_In/Dp_In into the shadow register
Load_Ack  output  1  1-cycle pulse when the shadow is committed to the active register
An_Out  output  NUM_DIGITS  digit anode drives
Seg_Out  output  7  segments, bit6=g .. bit0=a
Dp_Out  output  1  decimal point drive
Frame_Start  output  1  1-cycle pulse on entry to digit 0 of each frame

Behaviour:
- Reset (async, RST=1): state=S_BLANK; digit index=0; tick counter=0; shadow=0; active=0; pending=0; Load_Ack=0; Frame_Start=0. All of An_Out, Seg_Out and Dp_Out are driven to the "off" level: all 1s if ACTIVE_LOW, else all 0s.
- FSM states and transitions:
  - S_BLANK: all outputs off. The counter counts Tick_In. On the tick where counter==BLANK_TICKS-1, go to S_SHOW and clear the counter.
  - S_SHOW: drive digit[idx]. On the tick where counter==SHOW_TICKS-1:
    - idx wraps NUM_DIGITS-1 -> 0, otherwise idx+1;
    - enter S_BLANK, or go straight to S_SHOW of the next digit if BLANK_TICKS=0.
- Clock-edge rules: no state change on cycles without Tick_In. All outputs are registered and reflect the new state one Clk_In cycle after the tick edge.
- Frame boundary: the transition into idx=0 (blank or show phase). On that edge:
  - Frame_Start pulses for 1 cycle;
  - if pending=1, then active<=shadow, pending<=0, and Load_Ack pulses in the same cycle as Frame_Start.
- Frame period = NUM_DIGITS*(BLANK_TICKS+SHOW_TICKS) ticks; with the defaults, 16 ticks = 250 Hz refresh.
- Load handling:
  - Load captures Data_In/Dp_In into the shadow in the same cycle and sets pending.
  - Repeated Loads before a commit overwrite the shadow; they produce a single Load_Ack.
  - Load coinciding with a frame-boundary edge: the boundary commits the old shadow (if pending), the new data enters the shadow, and pending stays 1 for the next boundary.
- Show-phase drive for digit i:
  - The anode for bit i is on only if Digit_En[i]=1; otherwise all anodes are off, but slot timing is unchanged.
  - Segments come from the hex decode of active nibble i, standard 0-F glyphs (0=0111111, 1=0000110, A=1110111, F=1110001 in g..a order).
  - Dp_Out = active Dp bit i.
- Leading-zero suppression: with Lz_Suppress=1, digit i (i>0) has its segments forced off when it and every higher digit are 0. Digit 0 is never suppressed. The anode and Dp are still driven normally.
- ACTIVE_LOW inverts all three output groups at the final register stage only.
- Reset mid-scan takes effect immediately. Any pending Load is discarded and no Load_Ack is produced.

Decomposition:
- Shared package (seg_pkg): state encoding (S_BLANK, S_SHOW); the 16-entry hex-to-segment constant table; the SEG_OFF constant.
- One combinational sub-module: seg_hex_decoder (4-bit nibble -> 7-bit active-high segments).
- The FSM, counters, buffers and polarity stage stay in seg_scan_ctrl.

Test Plan:
- Reset: RST=1 with ACTIVE_LOW=1 -> An_Out=4'b1111, Seg_Out=7'h7F, Dp_Out=1, Load_Ack=0, and these hold while Tick_In toggles.
- Scan order: Load with Data_In=16'h12AF, defaults, periodic ticks -> Load_Ack coincides with the first Frame_Start, then:
  - pattern per digit: 1 blank tick, then 3 show ticks;
  - show phases run digits 0..3 with glyphs F, A, 2, 1 (active-low: An 1110, 1101, 1011, 0111);
  - Frame_Start every 16 ticks.
- Double buffering: Load 16'h1111 mid-frame -> the current frame completes with the old data; the new data appears on digit 0 after the next boundary; exactly one Load_Ack.
- Leading zeros: Data 16'h0030, Lz_Suppress=1 -> digits 3 and 2 have segments off, digit 1 shows 3, digit 0 shows 0. With Lz_Suppress=0 -> all four glyphs shown.
- Enables and BLANK_TICKS=0: Digit_En=4'b0101 -> digits 1 and 3 never light, frame still 4*SHOW_TICKS ticks, no blank phase.
- Edge cases:
  - Load on the boundary cycle -> the old shadow commits now and the new data commits at the following boundary.
  - RST pulsed mid-show -> outputs go off asynchronously and the scan restarts at digit 0 blank.
